// File: rtl/mealy_fsm_prog.sv
// Table-driven Mealy FSM. Each entry e[s][i] = {next, out} is indexed by
// {state_idx, in_vec}. The table resets to "every state self-loops with zero
// output" and can be rewritten through the cfg port while the machine runs.
module mealy_fsm_prog #(
  parameter  int N_STATES    = 5,
  parameter  int IN_W        = 2,
  parameter  int OUT_W       = 2,
  parameter  int ENC         = 2,
  parameter  int REG_OUT     = 0,
  parameter  int START_STATE = 0,
  localparam int SI_W        = (N_STATES > 1) ? $clog2(N_STATES) : 1
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                en,
  input  logic                clr,
  input  logic [IN_W-1:0]     in_vec,
  input  logic                cfg_we,
  input  logic [SI_W-1:0]     cfg_state,
  input  logic [IN_W-1:0]     cfg_in,
  input  logic [SI_W-1:0]     cfg_next,
  input  logic [OUT_W-1:0]    cfg_out,
  output logic [OUT_W-1:0]    out,
  output logic [SI_W-1:0]     state_idx,
  output logic [N_STATES-1:0] state_code,
  output logic                err
);

  localparam int AW   = SI_W + IN_W;
  localparam int TBL  = 1 << AW;
  localparam int SW1  = SI_W + 1;
  localparam logic [SI_W:0]         NS    = SW1'(N_STATES);
  localparam logic [SI_W-1:0]       START = SI_W'(START_STATE);
  localparam logic [N_STATES-1:0]   ONE   = N_STATES'(1);

  // Table is sized to the full address space so no index can fall outside
  // it; rows with state >= N_STATES are never read (guarded by state_ok).
  logic [SI_W-1:0]  nxt_tbl [TBL];
  logic [OUT_W-1:0] out_tbl [TBL];

  logic [AW-1:0]    rd_addr, wr_addr;
  logic             state_ok, cfg_ok;
  logic [SI_W-1:0]  cur_next;
  logic [OUT_W-1:0] cur_out;

  assign rd_addr  = {state_idx, in_vec};
  assign wr_addr  = {cfg_state, cfg_in};
  assign state_ok = ({1'b0, state_idx} < NS);
  assign cfg_ok   = ({1'b0, cfg_state} < NS) && ({1'b0, cfg_next} < NS);
  assign cur_next = state_ok ? nxt_tbl[rd_addr] : START;
  assign cur_out  = state_ok ? out_tbl[rd_addr] : '0;

  // Table storage: async reset to self-loop/zero-out, legal writes only.
  // Nonblocking update means a same-edge step still sees the old entry.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int e = 0; e < TBL; e++) begin
        nxt_tbl[e] <= ((e >> IN_W) < N_STATES) ? SI_W'(e >> IN_W) : START;
        out_tbl[e] <= '0;
      end
    end else if (cfg_we && cfg_ok) begin
      nxt_tbl[wr_addr] <= cfg_next;
      out_tbl[wr_addr] <= cfg_out;
    end
  end

  // State register and sticky error; clr beats en, an illegal state
  // recovers to START on the next edge regardless of en.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_idx <= START;
      err       <= 1'b0;
    end else if (clr) begin
      state_idx <= START;
      err       <= 1'b0;
    end else begin
      if (!state_ok) begin
        state_idx <= START;
        err       <= 1'b1;
      end else if (en) begin
        state_idx <= cur_next;
      end
      if (cfg_we && !cfg_ok) err <= 1'b1;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [OUT_W-1:0] out_q;
      // Registered outputs update with the state on each step edge.
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)   out_q <= '0;
        else if (clr) out_q <= '0;
        else if (en)  out_q <= cur_out;
      end
      assign out = out_q;
    end else begin : g_comb_out
      assign out = en ? cur_out : '0;
    end

    if (ENC == 1) begin : g_onehot
      assign state_code = ONE << state_idx;
    end else if (ENC == 2) begin : g_onecold
      assign state_code = ~(ONE << state_idx);
    end else begin : g_binary
      assign state_code = N_STATES'(state_idx);
    end
  endgenerate

endmodule

// File: tb/tb_mealy_fsm_prog.sv
// Directed bench: three instances share stimulus.
//   u0: ENC=2 (one-cold), REG_OUT=0
//   u1: ENC=0 (binary),   REG_OUT=1
//   u2: ENC=1 (one-hot),  REG_OUT=0
module tb_mealy_fsm_prog;

  logic       clk = 1'b0;
  logic       rst_b, en, clr, cfg_we;
  logic [1:0] in_vec, cfg_in, cfg_out;
  logic [2:0] cfg_state, cfg_next;

  logic [1:0] out0, out1, out2;
  logic [2:0] idx0, idx1, idx2;
  logic [4:0] code0, code1, code2;
  logic       err0, err1, err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mealy_fsm_prog #(.N_STATES(5), .IN_W(2), .OUT_W(2), .ENC(2), .REG_OUT(0), .START_STATE(0)) u0 (
    .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .in_vec(in_vec),
    .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_in(cfg_in), .cfg_next(cfg_next), .cfg_out(cfg_out),
    .out(out0), .state_idx(idx0), .state_code(code0), .err(err0));

  mealy_fsm_prog #(.N_STATES(5), .IN_W(2), .OUT_W(2), .ENC(0), .REG_OUT(1), .START_STATE(0)) u1 (
    .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .in_vec(in_vec),
    .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_in(cfg_in), .cfg_next(cfg_next), .cfg_out(cfg_out),
    .out(out1), .state_idx(idx1), .state_code(code1), .err(err1));

  mealy_fsm_prog #(.N_STATES(5), .IN_W(2), .OUT_W(2), .ENC(1), .REG_OUT(0), .START_STATE(0)) u2 (
    .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .in_vec(in_vec),
    .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_in(cfg_in), .cfg_next(cfg_next), .cfg_out(cfg_out),
    .out(out2), .state_idx(idx2), .state_code(code2), .err(err2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] s, input logic [1:0] i, input logic [2:0] n, input logic [1:0] o);
    cfg_state = s; cfg_in = i; cfg_next = n; cfg_out = o; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; en = 1'b0; clr = 1'b0; cfg_we = 1'b0; in_vec = 2'b00;
    cfg_state = '0; cfg_in = '0; cfg_next = '0; cfg_out = '0;
    #25;
    // reset state
    chk("rst_code_cold", code0, 5'b11110);
    chk("rst_code_bin",  code1, 5'b00000);
    chk("rst_code_hot",  code2, 5'b00001);
    chk("rst_out0", out0, 2'b00);
    chk("rst_out1", out1, 2'b00);
    chk("rst_err",  err0, 1'b0);
    #2 rst_b = 1'b1;
    tick();

    // default table: self-loop, zero out
    en = 1'b1; in_vec = 2'b11; #1;
    chk("dflt_out0", out0, 2'b00);
    tick();
    chk("dflt_idx",  idx0, 3'd0);
    chk("dflt_out1", out1, 2'b00);

    // program the table with en=0
    en = 1'b0;
    wr(3'd0, 2'b10, 3'd1, 2'b01);
    wr(3'd0, 2'b11, 3'd4, 2'b10);
    for (int i = 0; i < 4; i++) wr(3'd1, 2'(i), 3'd2, 2'b11);
    wr(3'd2, 2'b00, 3'd4, 2'b01);
    wr(3'd2, 2'b01, 3'd4, 2'b01);
    wr(3'd2, 2'b10, 3'd3, 2'b10);
    wr(3'd2, 2'b11, 3'd3, 2'b10);
    chk("prog_idx",  idx0, 3'd0);
    chk("prog_out0", out0, 2'b00);

    // run 10, 00, 10 : 0->1->2->3, out 01, 11, 10
    en = 1'b1; in_vec = 2'b10; #1;
    chk("run1_out0", out0, 2'b01);
    chk("run1_out2", out2, 2'b01);
    tick();
    chk("run1_idx",  idx0, 3'd1);
    chk("run1_out1", out1, 2'b01);
    in_vec = 2'b00; #1;
    chk("run2_out0", out0, 2'b11);
    tick();
    chk("run2_idx",  idx0, 3'd2);
    chk("run2_out1", out1, 2'b11);
    in_vec = 2'b10; #1;
    chk("run3_out0", out0, 2'b10);
    tick();
    chk("run3_idx",  idx0, 3'd3);
    chk("run3_out1", out1, 2'b10);
    chk("s3_cold", code0, 5'b10111);
    chk("s3_bin",  code1, 5'b00011);
    chk("s3_hot",  code2, 5'b01000);

    // back to start, step to 1
    en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_idx",  idx0, 3'd0);
    chk("clr_out1", out1, 2'b00);
    en = 1'b1; in_vec = 2'b10; tick();
    chk("to1_idx", idx0, 3'd1);

    // collision: step from 1 with in=00 while rewriting e[1][00]={0,00}
    in_vec = 2'b00;
    wr(3'd1, 2'b00, 3'd0, 2'b00);
    chk("coll_idx",  idx0, 3'd2);
    chk("coll_out1", out1, 2'b11);
    en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; in_vec = 2'b10; tick();
    chk("ret1_idx", idx0, 3'd1);
    in_vec = 2'b00; #1;
    chk("new_out0", out0, 2'b00);
    tick();
    chk("new_idx",  idx0, 3'd0);
    chk("new_out1", out1, 2'b00);

    // illegal write: cfg_next=5
    en = 1'b0;
    wr(3'd0, 2'b10, 3'd5, 2'b11);
    chk("ill_err0", err0, 1'b1);
    chk("ill_err1", err1, 1'b1);
    en = 1'b1; in_vec = 2'b10; #1;
    chk("ill_keep_out0", out0, 2'b01);
    tick();
    chk("ill_keep_idx", idx0, 3'd1);
    chk("ill_sticky",   err0, 1'b1);

    // en=0 hold for 3 cycles in state 1
    en = 1'b0; in_vec = 2'b01;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_idx",  idx0, 3'd1);
      chk("hold_out0", out0, 2'b00);
      chk("hold_out1", out1, 2'b01);
    end
    // clr with en: start state wins over e[1][01].next=2
    en = 1'b1; clr = 1'b1; #1;
    chk("pclr_out0", out0, 2'b11);
    tick(); clr = 1'b0; en = 1'b0;
    chk("pclr_idx",  idx0, 3'd0);
    chk("pclr_err",  err0, 1'b0);
    chk("pclr_out1", out1, 2'b00);
    chk("pclr_hot",  code2, 5'b00001);

    // async reset mid-run
    en = 1'b1; in_vec = 2'b10; tick();
    chk("pre_ar_idx", idx0, 3'd1);
    #2 rst_b = 1'b0; #1;
    chk("ar_idx",  idx0, 3'd0);
    chk("ar_cold", code0, 5'b11110);
    chk("ar_out1", out1, 2'b00);
    @(negedge clk) rst_b = 1'b1;
    #1;
    chk("ar_tbl_out0", out0, 2'b00);
    tick();
    chk("ar_tbl_idx", idx0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mealy_fsm_prog.md
# mealy_fsm_prog

Table-driven, run-time programmable Mealy state machine. It generalises the team's fixed 5-state, 2-input, 2-output one-cold controllers into one block with parametrised state count, input/output widths, state encoding and output registering. The transition/output table is loaded over a simple write port and can be rewritten while the machine runs. It is meant to replace hand-coded control FSMs in lab exercises and small datapath controllers.

## Interface
- N_STATES, 5, number of states (2..16)
- IN_W, 2, input vector width (1..4); the table has N_STATES·2^IN_W entries
- OUT_W, 2, output vector width (1..8)
- ENC, 2, state_code encoding: 0 binary, 1 one-hot, 2 one-cold
- REG_OUT, 0, 0 = combinational Mealy outputs; 1 = outputs registered on the transition edge
- START_STATE, 0, state index entered on reset and on clr
- SI_W (derived), clog2(N_STATES), state index width
- clk  in  1  clock, rising edge
- rst_b  in  1  reset, asynchronous, active-low
- en  in  1  step enable; the state advances only when en=1
- clr  in  1  synchronous restart to START_STATE; has priority over en
- in_vec  in  IN_W  machine inputs; bit order {a,b,...}, MSB first
- cfg_we  in  1  table write strobe
- cfg_state  in  SI_W  entry address: current-state part
- cfg_in  in  IN_W  entry address: input part
- cfg_next  in  SI_W  next-state index to store
- cfg_out  in  OUT_W  output value to store
- out  out  OUT_W  machine outputs
- state_idx  out  SI_W  current state index
- state_code  out  N_STATES  encoded state; for binary, the index is zero-extended
- err  out  1  sticky error flag

## Operation
- Table entry e[s][i] = {next, out}. Reset initialises every entry to {next=s, out=0}, so every state self-loops with zero output.
- Write: when cfg_we=1 on a rising edge, entry e[cfg_state][cfg_in] is loaded.
  - The write is ignored, and err is set, if cfg_state ≥ N_STATES or cfg_next ≥ N_STATES.
- Step: on a rising edge with en=1 and clr=0, state_idx ← e[state_idx][in_vec].next.
- Step and write in the same edge: the step uses the pre-write entry, including when the write targets the entry being used.
- Stored outputs:
  - REG_OUT=0: out = e[state_idx][in_vec].out when en=1, otherwise 0. This is combinational from in_vec.
  - REG_OUT=1: on each step edge, out ← e[state_idx][in_vec].out. out holds when en=0 and clears to 0 on clr.
- Encoding of state_code:
  - one-hot: bit state_idx = 1, all other bits 0.
  - one-cold: bit state_idx = 0, all other bits 1. For N_STATES=5, S0 = 5'b11110 (bit0 low).
  - binary: state_code = state_idx, zero-extended.
- err: set by an illegal write. Also set if state_idx is ever ≥ N_STATES; in that case the next edge forces START_STATE. err is cleared only by rst_b or by clr.
- clr=1: state_idx ← START_STATE and err ← 0. A cfg write in the same edge still takes effect.

## Timing
- Reset values:
  - state_idx = START_STATE; state_code = encoding of START_STATE.
  - err = 0; table at its default.
  - out = 0 in both modes. In REG_OUT=0 this follows from the default table.
- REG_OUT=0: out is valid in the same cycle as in_vec (zero latency), and state_idx updates one edge later.
- REG_OUT=1: out and state_idx update on the same edge, giving one cycle of output latency.
- A table write is visible to steps from the edge after the write.
- rst_b asserted mid-run clears the state and the table immediately, without waiting for clk. All outputs go to reset values while rst_b=0.

## Test plan
- Reset: N_STATES=5, ENC=2, rst_b low 25 ns.
  - Required: state_code=5'b11110, out=0, err=0.
  - With en=1 and any in_vec: state holds and out=0 (default table).
- Program a 5-state table, with in_vec={a,b}: e[0][10]={1,01}, e[0][11]={4,10}, e[1][xx]={2,11}, e[2][0x]={4,01}, e[2][1x]={3,10}.
  - Drive 10, 00, 10 with en=1.
  - Required: states 0→1→2→3, out 01, 11, 10 (REG_OUT=0).
  - Same sequence with REG_OUT=1: the same out values, each one cycle later.
- Write/step collision: in state 1 with entry e[1][00]={2,11}, write e[1][00]={0,00} in the same edge as a step.
  - Required: next state is 2.
  - After returning to state 1, the next step goes to state 0.
- Illegal write: write with cfg_next=5 (N_STATES=5).
  - Required: entry unchanged, err=1 and stays 1.
  - clr pulse: err=0 and state = START_STATE.
- en/clr priority: en=0 for 3 cycles, then clr=1 together with en=1.
  - Required: state held during en=0; out=0 (REG_OUT=0) or held (REG_OUT=1).
  - On the clr edge: state goes to START_STATE, not to the table's next state.
- Encodings: rerun the reset and table-program scenarios with ENC=0 and ENC=1.
  - ENC=0: state_code=5'b00011 in state 3.
  - ENC=1: state_code=5'b01000 in state 3.
